// File: rtl/instr_issue_reg.sv
// Instruction register ahead of the data_mux select stage: decodes a byte stream into a held (sel, reg, imm) instruction.
// Optional IMM-wait timeout is enabled with `define INSTR_ISSUE_REG_IMM_TIMEOUT_EN.
module instr_issue_reg #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ERR_CNT_W   = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           sel,
  output logic [4:0]           reg_fld,
  output logic [DATA_W-1:0]    imm,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   out_valid_d;
  logic [2:0]             sel_d;
  logic [4:0]             reg_d;
  logic [DATA_W-1:0]      imm_d;
  logic [ERR_CNT_W-1:0]   err_d;
  logic                   accept;
  logic                   decode;
  logic [2:0]             opcode;

`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
  localparam int unsigned WAIT_W = 5;
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // Only a held, unaccepted instruction can stall the upstream byte stream.
  assign in_ready = (state_q != S_HOLD) || out_ready;
  assign accept   = in_valid && in_ready;
  assign opcode   = in_data[7:5];

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    reg_d   = reg_fld;
    imm_d   = imm;
    err_d   = err_cnt;
    decode  = 1'b0;
`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
    wait_d  = wait_q;
`endif

    case (state_q)
      S_FETCH: begin
        decode = accept;
      end
      S_IMM: begin
        if (accept) begin
          imm_d   = in_data;
          state_d = S_HOLD;
        end
`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_FETCH;
          if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_CNT_W'(1);
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (out_ready) begin
          if (in_valid) decode = 1'b1;
          else          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Opcode byte handling shared by FETCH and back-to-back issue from HOLD
    if (decode) begin
      case (opcode)
        3'b000, 3'b001: begin
          sel_d   = opcode;
          reg_d   = in_data[4:0];
          imm_d   = '0;
          state_d = S_HOLD;
        end
        3'b010: begin
          sel_d   = opcode;
          reg_d   = in_data[4:0];
          state_d = S_IMM;
`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
        default: begin
          state_d = S_FETCH;
          if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_CNT_W'(1);
        end
      endcase
    end

    out_valid_d = (state_d == S_HOLD);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      out_valid <= 1'b0;
      sel       <= 3'b000;
      reg_fld   <= '0;
      imm       <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= out_valid_d;
      sel       <= sel_d;
      reg_fld   <= reg_d;
      imm       <= imm_d;
      err_cnt   <= err_d;
    end
  end

`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
  // Cycles spent in IMM without the immediate byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

endmodule

// File: tb/tb_instr_issue_reg.sv
// Randomized and directed self-checking bench for instr_issue_reg against a transaction-level reference model.
module tb_instr_issue_reg;

  localparam int TIMEOUT = 15;
  localparam int ERR_SAT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] sel;
  logic [4:0] reg_fld;
  logic [7:0] imm;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction currently on offer and the one being assembled
  bit       m_hold, m_wimm;
  bit [2:0] m_sel;
  bit [4:0] m_reg;
  bit [7:0] m_imm;
  int       m_err, m_wcnt;
  bit       obs_ready, exp_ready;

  instr_issue_reg #(.DATA_W(8), .ERR_CNT_W(4), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .reg_fld(reg_fld),
    .imm(imm), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hold = 0; m_wimm = 0; m_sel = 0; m_reg = 0; m_imm = 0; m_err = 0; m_wcnt = 0;
  endtask

  // One clock: drive inputs, sample in_ready before the edge, advance the model at the edge
  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    int op;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    obs_ready = in_ready;
    exp_ready = !m_hold || r;
    @(posedge clk);
    if (v && exp_ready) begin
      if (m_wimm) begin
        m_imm = d; m_wimm = 0; m_hold = 1;
      end else begin
        op = int'(d[7:5]);
        if (op <= 2) begin
          m_sel = 3'(op); m_reg = d[4:0];
          if (op == 2) begin m_wimm = 1; m_hold = 0; m_wcnt = 0; end
          else begin m_imm = 0; m_hold = 1; end
        end else begin
          m_hold = 0;
          if (m_err < ERR_SAT) m_err++;
        end
      end
    end else begin
      if (m_hold && r) m_hold = 0;
`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
      if (m_wimm) begin
        m_wcnt++;
        if (m_wcnt == TIMEOUT) begin
          m_wimm = 0;
          if (m_err < ERR_SAT) m_err++;
        end
      end
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if ({sel, reg_fld, imm} !== 16'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {sel, reg_fld, imm}); end
    checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    tick(1, 8'h05, 1);
    checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b000, 5'd5, 8'h00}) begin
      errors++; $display("FAIL single_issue: got v=%b sel=%b reg=%0d imm=%h want v=1 sel=000 reg=5 imm=00", out_valid, sel, reg_fld, imm); end
    tick(0, 8'h00, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_imm();
    do_reset();
    tick(1, 8'h43, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL imm_early_valid: got %b want 0", out_valid); end
    tick(1, 8'hA5, 1);
    checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b010, 5'd3, 8'hA5}) begin
      errors++; $display("FAIL imm_issue: got v=%b sel=%b reg=%0d imm=%h want v=1 sel=010 reg=3 imm=a5", out_valid, sel, reg_fld, imm); end
    tick(0, 8'h00, 1);
  endtask

  task automatic test_hold();
    do_reset();
    tick(1, 8'h21, 1);
    checks++; if ({out_valid, sel, reg_fld} !== {1'b1, 3'b001, 5'd1}) begin
      errors++; $display("FAIL hold_load: got v=%b sel=%b reg=%0d want v=1 sel=001 reg=1", out_valid, sel, reg_fld); end
    for (int i = 0; i < 5; i++) begin
      tick(1, 8'h02, 0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, obs_ready); end
      checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b001, 5'd1, 8'h00}) begin
        errors++; $display("FAIL hold_stable[%0d]: got v=%b sel=%b reg=%0d imm=%h", i, out_valid, sel, reg_fld, imm); end
    end
    tick(1, 8'h02, 1);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", obs_ready); end
    checks++; if ({out_valid, sel, reg_fld} !== {1'b1, 3'b000, 5'd2}) begin
      errors++; $display("FAIL hold_handoff: got v=%b sel=%b reg=%0d want v=1 sel=000 reg=2", out_valid, sel, reg_fld); end
    tick(0, 8'h00, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tick(1, 8'(i), 1);
      checks++; if ({out_valid, reg_fld} !== {1'b1, 5'(i)}) begin
        errors++; $display("FAIL b2b[%0d]: got v=%b reg=%0d want v=1 reg=%0d", i, out_valid, reg_fld, i); end
    end
    tick(0, 8'h00, 1);
  endtask

  task automatic test_illegal();
    do_reset();
    tick(1, 8'h60, 1);
    tick(1, 8'hFF, 1);
    checks++; if ({out_valid, err_cnt} !== {1'b0, 4'd2}) begin
      errors++; $display("FAIL illegal_drop: got v=%b err=%0d want v=0 err=2", out_valid, err_cnt); end
    tick(1, 8'h01, 1);
    checks++; if ({out_valid, sel, reg_fld, err_cnt} !== {1'b1, 3'b000, 5'd1, 4'd2}) begin
      errors++; $display("FAIL illegal_next: got v=%b sel=%b reg=%0d err=%0d", out_valid, sel, reg_fld, err_cnt); end
    for (int i = 0; i < 20; i++) begin
      tick(1, {3'($urandom_range(3, 7)), 5'($urandom)}, 1);
      checks++; if (err_cnt !== 4'(m_err)) begin errors++; $display("FAIL illegal_cnt[%0d]: got %0d want %0d", i, err_cnt, m_err); end
    end
    checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL illegal_sat: got %0d want 15", err_cnt); end
  endtask

  task automatic test_reset_mid_imm();
    do_reset();
    tick(1, 8'hE0, 1);
    tick(1, 8'h40, 1);
    rst = 1;
    #1;
    checks++; if ({out_valid, sel, err_cnt} !== {1'b0, 3'b000, 4'd0}) begin
      errors++; $display("FAIL rst_async: got v=%b sel=%b err=%0d want v=0 sel=000 err=0", out_valid, sel, err_cnt); end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    tick(1, 8'h01, 1);
    checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b000, 5'd1, 8'h00}) begin
      errors++; $display("FAIL rst_then_opcode: got v=%b sel=%b reg=%0d imm=%h", out_valid, sel, reg_fld, imm); end
    tick(0, 8'h00, 1);
  endtask

  task automatic test_imm_idle();
    do_reset();
    tick(1, 8'h40, 1);
`ifdef INSTR_ISSUE_REG_IMM_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      tick(0, 8'h00, 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid[%0d]: got %b want 0", i, out_valid); end
    end
    checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_cnt); end
    tick(1, 8'h41, 1);
    tick(1, 8'h10, 1);
    checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b010, 5'd1, 8'h10}) begin
      errors++; $display("FAIL timeout_recover: got v=%b sel=%b reg=%0d imm=%h", out_valid, sel, reg_fld, imm); end
`else
    for (int i = 0; i < 30; i++) tick(0, 8'h00, 1);
    checks++; if ({out_valid, err_cnt} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL imm_wait: got v=%b err=%0d want v=0 err=0", out_valid, err_cnt); end
    tick(1, 8'h10, 1);
    checks++; if ({out_valid, sel, reg_fld, imm} !== {1'b1, 3'b010, 5'd0, 8'h10}) begin
      errors++; $display("FAIL imm_late: got v=%b sel=%b reg=%0d imm=%h", out_valid, sel, reg_fld, imm); end
`endif
    tick(0, 8'h00, 1);
  endtask

  task automatic test_random();
    bit v, r;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:5] = 3'($urandom_range(0, 2));
      tick(v, d, r);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
      checks++; if (out_valid !== m_hold) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_hold); end
      checks++; if (err_cnt !== 4'(m_err)) begin errors++; $display("FAIL rnd_err[%0d]: got %0d want %0d", i, err_cnt, m_err); end
      if (m_hold) begin
        checks++; if ({sel, reg_fld, imm} !== {m_sel, m_reg, m_imm}) begin
          errors++; $display("FAIL rnd_fields[%0d]: got sel=%b reg=%0d imm=%h want sel=%b reg=%0d imm=%h",
                             i, sel, reg_fld, imm, m_sel, m_reg, m_imm); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm();
    test_hold();
    test_back_to_back();
    test_illegal();
    test_reset_mid_imm();
    test_imm_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
